// File: rtl/bp_event_counter_bank.sv
// Bank of event counters plus a cycle counter with sticky overflow flags,
// atomic snapshot into shadow registers, and a registered shadow read port.
module bp_event_counter_bank #(
  parameter int width_p      = 32,
  parameter int num_events_p = 32,
  parameter bit saturate_p   = 1'b0,
  localparam int lg_ch_lp    = (num_events_p + 1 > 1) ? $clog2(num_events_p + 1) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    clear_i,
  input  logic [num_events_p-1:0] event_v_i,
  input  logic                    snapshot_i,
  input  logic                    rd_v_i,
  input  logic [lg_ch_lp-1:0]     rd_addr_i,
  output logic                    rd_v_o,
  output logic [width_p-1:0]      rd_data_o,
  output logic [num_events_p:0]   ovf_o
);

  localparam int n_lp = num_events_p + 1;

  logic [width_p-1:0] cnt_r    [n_lp];
  logic [width_p-1:0] shadow_r [n_lp];
  logic [n_lp-1:0]    ovf_r;
  logic [n_lp-1:0]    inc;
  logic [width_p-1:0] rd_sel;
  logic               rd_v_r;
  logic [width_p-1:0] rd_data_r;

  // The top slot is the cycle counter, which only needs the enable.
  assign inc = {en_i, event_v_i & {num_events_p{en_i}}};

  // NOTE: all state below uses non-blocking assignments so every counter
  // samples the same pre-edge values, which is what makes the snapshot atomic.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < n_lp; i++) cnt_r[i] <= '0;
      ovf_r <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < n_lp; i++) cnt_r[i] <= '0;
      ovf_r <= '0;
    end else begin
      for (int i = 0; i < n_lp; i++) begin
        if (inc[i]) begin
          if (&cnt_r[i]) begin
            ovf_r[i] <= 1'b1;
            if (!saturate_p) cnt_r[i] <= '0;
          end else begin
            cnt_r[i] <= cnt_r[i] + width_p'(1);
          end
        end
      end
    end
  end

  // NOTE: the shadow array is a register file that must read back as zero
  // after reset, so it is reset like any other flop rather than left as RAM.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < n_lp; i++) shadow_r[i] <= '0;
    end else if (snapshot_i) begin
      for (int i = 0; i < n_lp; i++) shadow_r[i] <= cnt_r[i];
    end
  end

  // Addresses past the cycle counter match nothing and fall through to zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < n_lp; i++) begin
      if (rd_addr_i == lg_ch_lp'(i)) rd_sel = shadow_r[i];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_v_r    <= 1'b0;
      rd_data_r <= '0;
    end else begin
      rd_v_r <= rd_v_i;
      if (rd_v_i) rd_data_r <= rd_sel;
    end
  end

  assign rd_v_o    = rd_v_r;
  assign rd_data_o = rd_data_r;
  assign ovf_o     = ovf_r;

endmodule

// File: tb/tb_bp_event_counter_bank.sv
// Drives a wrapping and a saturating 4-bit bank with identical stimulus and
// checks both against an unbounded-count reference model.
module tb_bp_event_counter_bank;

  localparam int W    = 4;
  localparam int N    = 6;
  localparam int LG   = 3;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         en_i = 1'b0;
  logic         clear_i = 1'b0;
  logic [N-1:0] event_v_i = '0;
  logic         snapshot_i = 1'b0;
  logic         rd_v_i = 1'b0;
  logic [LG-1:0] rd_addr_i = '0;

  logic         rd_v_w, rd_v_s;
  logic [W-1:0] rd_data_w, rd_data_s;
  logic [N:0]   ovf_w, ovf_s;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: raw event totals since the last clear; wrap/saturate applied on compare.
  int m_cnt [N+1];
  int m_sh  [N+1];
  bit exp_rd_v;
  int exp_rd_c;

  always #5 clk = ~clk;

  bp_event_counter_bank #(.width_p(W), .num_events_p(N), .saturate_p(1'b0)) dut_wrap (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .clear_i(clear_i),
    .event_v_i(event_v_i), .snapshot_i(snapshot_i), .rd_v_i(rd_v_i),
    .rd_addr_i(rd_addr_i), .rd_v_o(rd_v_w), .rd_data_o(rd_data_w), .ovf_o(ovf_w));

  bp_event_counter_bank #(.width_p(W), .num_events_p(N), .saturate_p(1'b1)) dut_sat (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .clear_i(clear_i),
    .event_v_i(event_v_i), .snapshot_i(snapshot_i), .rd_v_i(rd_v_i),
    .rd_addr_i(rd_addr_i), .rd_v_o(rd_v_s), .rd_data_o(rd_data_s), .ovf_o(ovf_s));

  function automatic int wrap_val(int c);
    return c % (MAXV + 1);
  endfunction

  function automatic int sat_val(int c);
    return (c > MAXV) ? MAXV : c;
  endfunction

  function automatic logic [N:0] exp_ovf();
    logic [N:0] v;
    for (int i = 0; i <= N; i++) v[i] = (m_cnt[i] > MAXV);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= N; i++) begin
      m_cnt[i] = 0;
      m_sh[i]  = 0;
    end
    exp_rd_v = 1'b0;
    exp_rd_c = 0;
  endtask

  task automatic model_step();
    if (rd_v_i) begin
      exp_rd_v = 1'b1;
      exp_rd_c = (int'(rd_addr_i) <= N) ? m_sh[rd_addr_i] : 0;
    end else begin
      exp_rd_v = 1'b0;
    end
    if (snapshot_i)
      for (int i = 0; i <= N; i++) m_sh[i] = m_cnt[i];
    if (clear_i) begin
      for (int i = 0; i <= N; i++) m_cnt[i] = 0;
    end else if (en_i) begin
      for (int i = 0; i < N; i++) if (event_v_i[i]) m_cnt[i]++;
      m_cnt[N]++;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_rdv_w"}, 32'(rd_v_w), 32'(exp_rd_v));
    check({tag, "_rdv_s"}, 32'(rd_v_s), 32'(exp_rd_v));
    check({tag, "_rdd_w"}, 32'(rd_data_w), 32'(wrap_val(exp_rd_c)));
    check({tag, "_rdd_s"}, 32'(rd_data_s), 32'(sat_val(exp_rd_c)));
    check({tag, "_ovf_w"}, 32'(ovf_w), 32'(exp_ovf()));
    check({tag, "_ovf_s"}, 32'(ovf_s), 32'(exp_ovf()));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    if (!reset_i) model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic do_read(input int addr);
    rd_v_i    = 1'b1;
    rd_addr_i = LG'(addr);
    cycle("read");
    rd_v_i = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check("reset_rdv", 32'(rd_v_w), 32'd0);
    check("reset_ovf", 32'(ovf_s), 32'd0);
    compare_all("reset");
    cycle("reset_hold");
    cycle("reset_hold");
    reset_i = 1'b0;

    // Basic counting: 10 pulses on channel 3 over 20 enabled cycles.
    en_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      event_v_i = (i % 2 == 0) ? N'(8) : '0;
      cycle("count");
    end
    event_v_i  = '0;
    snapshot_i = 1'b1;
    cycle("snap1");
    snapshot_i = 1'b0;
    en_i       = 1'b0;
    do_read(3);
    check("t1_ch3_w", 32'(rd_data_w), 32'd10);
    check("t1_ch3_s", 32'(rd_data_s), 32'd10);
    do_read(N);
    check("t1_chN_w", 32'(rd_data_w), 32'd4);
    check("t1_chN_s", 32'(rd_data_s), 32'd15);
    do_read(0);
    check("t1_ch0_w", 32'(rd_data_w), 32'd0);
    check("t1_ovf_ev", 32'(ovf_w[N-1:0]), 32'd0);
    check("t1_ovf_cyc", 32'(ovf_s[N]), 32'd1);

    // Overflow: channel 0 held for 17 cycles.
    clear_i = 1'b1;
    cycle("clr2");
    clear_i   = 1'b0;
    en_i      = 1'b1;
    event_v_i = N'(1);
    for (int i = 0; i < 17; i++) cycle("ovf_run");
    en_i       = 1'b0;
    event_v_i  = '0;
    snapshot_i = 1'b1;
    cycle("snap2");
    snapshot_i = 1'b0;
    do_read(0);
    check("t2_wrap_ch0", 32'(rd_data_w), 32'd1);
    check("t2_sat_ch0", 32'(rd_data_s), 32'd15);
    check("t2_ovf0_w", 32'(ovf_w[0]), 32'd1);
    check("t2_ovf0_s", 32'(ovf_s[0]), 32'd1);

    // Atomic snapshot + clear after 7 channel-5 events.
    clear_i = 1'b1;
    cycle("clr3");
    clear_i   = 1'b0;
    en_i      = 1'b1;
    event_v_i = N'(32);
    for (int i = 0; i < 7; i++) cycle("ev5");
    en_i       = 1'b0;
    event_v_i  = '0;
    clear_i    = 1'b1;
    snapshot_i = 1'b1;
    cycle("snapclr");
    clear_i    = 1'b0;
    snapshot_i = 1'b0;
    check("t3_ovf_clear", 32'(ovf_w), 32'd0);
    do_read(5);
    check("t3_shadow_ch5", 32'(rd_data_w), 32'd7);
    snapshot_i = 1'b1;
    cycle("snap3b");
    snapshot_i = 1'b0;
    do_read(5);
    check("t3_live_ch5", 32'(rd_data_s), 32'd0);

    // Clear beats a same-cycle increment; disabled events change nothing.
    en_i      = 1'b1;
    event_v_i = N'(4);
    clear_i   = 1'b1;
    cycle("clr_ev2");
    clear_i   = 1'b0;
    en_i      = 1'b0;
    event_v_i = '1;
    for (int i = 0; i < 5; i++) cycle("dis");
    event_v_i  = '0;
    snapshot_i = 1'b1;
    cycle("snap4");
    snapshot_i = 1'b0;
    do_read(2);
    check("t4_ch2", 32'(rd_data_w), 32'd0);
    do_read(N);
    check("t4_chN", 32'(rd_data_w), 32'd0);

    // Back-to-back reads with a snapshot alongside the first read.
    en_i      = 1'b1;
    event_v_i = '1;
    cycle("pre5");
    cycle("pre5");
    en_i = 1'b0;
    snapshot_i = 1'b1;
    cycle("snap5a");
    snapshot_i = 1'b0;
    en_i = 1'b1;
    for (int i = 0; i < 3; i++) cycle("pre5b");
    en_i       = 1'b0;
    event_v_i  = '0;
    rd_v_i     = 1'b1;
    rd_addr_i  = LG'(0);
    snapshot_i = 1'b1;
    cycle("b2b_a");
    check("t5_a_v", 32'(rd_v_w), 32'd1);
    check("t5_a_old", 32'(rd_data_w), 32'd2);
    snapshot_i = 1'b0;
    rd_addr_i  = LG'(N);
    cycle("b2b_b");
    check("t5_b_v", 32'(rd_v_s), 32'd1);
    check("t5_b_new", 32'(rd_data_s), 32'd5);
    rd_addr_i = LG'(N + 1);
    cycle("b2b_c");
    check("t5_c_v", 32'(rd_v_w), 32'd1);
    check("t5_c_oor", 32'(rd_data_w), 32'd0);
    rd_v_i = 1'b0;
    cycle("b2b_idle");
    check("t5_idle_v", 32'(rd_v_w), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en_i       = ($urandom_range(3) != 0);
      event_v_i  = N'($urandom);
      clear_i    = ($urandom_range(31) == 0);
      snapshot_i = ($urandom_range(7) == 0);
      rd_v_i     = $urandom_range(1);
      rd_addr_i  = LG'($urandom);
      cycle("rand");
    end
    clear_i    = 1'b0;
    snapshot_i = 1'b0;

    // Asynchronous reset in the middle of counting and reading.
    en_i      = 1'b1;
    rd_v_i    = 1'b1;
    rd_addr_i = LG'(N);
    for (int i = 0; i < 3; i++) begin
      event_v_i = N'($urandom);
      cycle("prerst");
    end
    #2;
    reset_i = 1'b1;
    #1;
    check("t6_rdv_async", 32'(rd_v_w), 32'd0);
    check("t6_rdd_async", 32'(rd_data_s), 32'd0);
    check("t6_ovf_async", 32'(ovf_w), 32'd0);
    model_reset();
    compare_all("t6_async");
    rd_v_i = 1'b0;
    cycle("rst_hold");
    cycle("rst_hold");
    reset_i   = 1'b0;
    event_v_i = N'(2);
    for (int i = 0; i < 4; i++) cycle("post_rst");
    en_i       = 1'b0;
    event_v_i  = '0;
    snapshot_i = 1'b1;
    cycle("snap6");
    snapshot_i = 1'b0;
    do_read(1);
    check("t6_ch1", 32'(rd_data_w), 32'd4);
    do_read(N);
    check("t6_chN", 32'(rd_data_s), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_event_counter_bank.md
# bp_event_counter_bank

Parametrised bank of `num_events_p` event counters plus one cycle counter, all gated by a common enable. Every counter has a configurable width and a choice of saturating or wrapping overflow, with sticky overflow flags. An atomic snapshot copies all live counts into shadow registers, and a registered read port returns any shadow value by index. The bank sits beside the core profiler and takes one-hot or multi-hot stall/event strobes; software reads the results through the host register bridge.

## Interface
Parameters:
- `width_p`, 32: width of each counter and of `rd_data_o`.
- `num_events_p`, 32: number of event channels; legal range 1..255.
- `saturate_p`, 0: 1 = counters saturate at 2^width_p-1; 0 = counters wrap to 0.
- `lg_ch_lp`: localparam, `BSG_SAFE_CLOG2(num_events_p+1)`.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1  clock.
- `reset_i`  in  1  asynchronous active-high reset.
- `en_i`  in  1  global count enable.
- `clear_i`  in  1  synchronous clear of all live counters and overflow flags.
- `event_v_i`  in  num_events_p  per-channel increment strobe; any number of bits may be set per cycle.
- `snapshot_i`  in  1  copy all live counters into the shadow registers.
- `rd_v_i`  in  1  read request.
- `rd_addr_i`  in  lg_ch_lp  channel index; index num_events_p selects the cycle counter.
- `rd_v_o`  out  1  read data valid.
- `rd_data_o`  out  width_p  shadow value of the requested channel.
- `ovf_o`  out  num_events_p+1  sticky overflow flags; bit num_events_p belongs to the cycle counter.

## Operation
- Live counters: cnt[i] for i < num_events_p increments by 1 when `en_i & event_v_i[i]`. The cycle counter cnt[N], where N = num_events_p, increments when `en_i` is high.
- Overflow on an increment at 2^width_p-1:
  - `saturate_p`=1: the counter holds at max.
  - `saturate_p`=0: the counter wraps to 0.
  - In both modes the matching `ovf_o` bit sets and stays set until `clear_i` or reset.
- `clear_i`: all live counters go to 0 and all `ovf_o` bits go to 0 on the next edge. Clear takes priority over a same-cycle increment. Shadow registers are not affected by clear.
- `snapshot_i`: on the next edge, shadow[i] takes the pre-edge live value cnt[i] for all i at once. The snapshot excludes any increment from the same cycle.
- `snapshot_i` and `clear_i` in the same cycle: the shadow gets the pre-clear values and the live counters go to 0. This pair is the required atomic read-and-reset operation.
- Read: `rd_v_i` with `rd_addr_i`=a gives `rd_v_o`=1 and `rd_data_o`=shadow[a] on the next cycle.
  - Addresses greater than num_events_p return 0 with `rd_v_o`=1.
  - A read issued in the same cycle as `snapshot_i` returns the old shadow value.
  - When `rd_v_o`=0, `rd_data_o` holds its last value.
- There is no backpressure; a read may be issued every cycle.

## Timing
- Reset (asynchronous, takes effect immediately, released synchronously by the environment) sets the following to 0: all live counters, all shadows, `ovf_o`, `rd_v_o`, `rd_data_o`.
- Increment latency: 1 cycle, from strobe to updated live count.
- Snapshot latency: shadow is updated 1 cycle after `snapshot_i`. A read issued in the cycle after `snapshot_i` sees the new values.
- Read latency: exactly 1 cycle. The read data register is the only path to `rd_data_o`, so the read path has no combinational path from `rd_addr_i`.
- `ovf_o` is registered. It asserts in the same edge as the wrap or saturation event.
- Reset asserted in the middle of a read: `rd_v_o` drops immediately. The request is not replayed after reset.

## Test plan
- Reset, then `en_i`=1 with `event_v_i[3]` pulsed for 10 cycles over 20 cycles, then snapshot -> read ch3 = 10, ch N = 20 (cycles before the snapshot edge), ch 0 = 0, ovf_o = 0.
- `width_p`=4, `saturate_p`=0, event 0 held for 17 cycles, then snapshot -> ch0 reads 1 and ovf_o[0] = 1. Repeat with `saturate_p`=1 -> reads 15 and ovf_o[0] = 1.
- `clear_i` and `snapshot_i` in the same cycle after 7 event-5 increments -> shadow ch5 = 7 and live ch5 = 0. A second snapshot with no new events -> ch5 reads 0.
- `clear_i` together with `event_v_i[2]`=1 -> live ch2 = 0. `en_i`=0 with all events high for 5 cycles -> no counter changes.
- Back-to-back reads of addresses 0, N, N+1 in consecutive cycles, with `snapshot_i` in the same cycle as the first read -> the first read returns the old shadow, the next returns the new ch N, and address N+1 returns 0. `rd_v_o` is high for 3 consecutive cycles.
- Assert `reset_i` mid-count with events active -> all outputs are 0 in the same cycle, before the next clock edge, and counting resumes from 0 after release.
